// File: rtl/decode_pkg.sv
// Decode-stage package: opcode constants, control-word bit map, FSM states
// and the opcode decode helpers shared by the decode stage and its bench.
package decode_pkg;

   localparam int unsigned OPC_BITS = 4;
   localparam int unsigned CS_BITS  = 16;
   localparam int unsigned ALU_BITS = 3;

   typedef enum logic {
      ST_OPC = 1'b0,
      ST_IMM = 1'b1
   } state_e;

   localparam logic [OPC_BITS-1:0] OPC_NOP  = 4'h0;
   localparam logic [OPC_BITS-1:0] OPC_ADD  = 4'h1;
   localparam logic [OPC_BITS-1:0] OPC_SUB  = 4'h2;
   localparam logic [OPC_BITS-1:0] OPC_AND  = 4'h3;
   localparam logic [OPC_BITS-1:0] OPC_OR   = 4'h4;
   localparam logic [OPC_BITS-1:0] OPC_NOT  = 4'h5;
   localparam logic [OPC_BITS-1:0] OPC_MOV  = 4'h6;
   localparam logic [OPC_BITS-1:0] OPC_SETC = 4'h7;
   localparam logic [OPC_BITS-1:0] OPC_LDD  = 4'h8;
   localparam logic [OPC_BITS-1:0] OPC_STD  = 4'h9;
   localparam logic [OPC_BITS-1:0] OPC_JMP  = 4'hA;
   localparam logic [OPC_BITS-1:0] OPC_CALL = 4'hB;
   localparam logic [OPC_BITS-1:0] OPC_LDM  = 4'hC;
   localparam logic [OPC_BITS-1:0] OPC_IADD = 4'hD;
   localparam logic [OPC_BITS-1:0] OPC_RET  = 4'hE;
   localparam logic [OPC_BITS-1:0] OPC_RTI  = 4'hF;

   // Control-word bit indices; ALU_OP occupies ALU_BITS bits starting at 0.
   localparam int unsigned CS_ALU_OP     = 0;
   localparam int unsigned CS_ALU_SRC    = 3;
   localparam int unsigned CS_REG_WR     = 4;
   localparam int unsigned CS_MEM_RD     = 5;
   localparam int unsigned CS_MEM_WR     = 6;
   localparam int unsigned CS_MEM_TO_REG = 7;
   localparam int unsigned CS_BRANCH     = 8;
   localparam int unsigned CS_JUMP       = 9;
   localparam int unsigned CS_IMM_SEL    = 10;
   localparam int unsigned CS_PUSH_PC    = 11;
   localparam int unsigned CS_POP_PC     = 12;
   localparam int unsigned CS_RESET_CALL = 13;
   localparam int unsigned CS_SET_C      = 14;
   localparam int unsigned CS_RESET_RTI  = 15;

   localparam logic [CS_BITS-1:0] CS_NOP = '0;
   localparam logic [CS_BITS-1:0] CS_INT = (CS_BITS'(1) << CS_PUSH_PC)
                                         | (CS_BITS'(1) << CS_RESET_CALL);

   // Opcodes followed by an immediate word.
   function automatic logic needs_imm(input logic [OPC_BITS-1:0] opc);
      return (opc == OPC_LDD) || (opc == OPC_STD) ||
             (opc == OPC_LDM) || (opc == OPC_IADD);
   endfunction

   // Opcode to control word.
   function automatic logic [CS_BITS-1:0] decode(input logic [OPC_BITS-1:0] opc);
      logic [CS_BITS-1:0] cs;
      cs = CS_NOP;
      case (opc)
         OPC_ADD:  begin cs[CS_ALU_OP +: ALU_BITS] = 3'd1; cs[CS_REG_WR] = 1'b1; end
         OPC_SUB:  begin cs[CS_ALU_OP +: ALU_BITS] = 3'd2; cs[CS_REG_WR] = 1'b1; end
         OPC_AND:  begin cs[CS_ALU_OP +: ALU_BITS] = 3'd3; cs[CS_REG_WR] = 1'b1; end
         OPC_OR:   begin cs[CS_ALU_OP +: ALU_BITS] = 3'd4; cs[CS_REG_WR] = 1'b1; end
         OPC_NOT:  begin cs[CS_ALU_OP +: ALU_BITS] = 3'd5; cs[CS_REG_WR] = 1'b1; end
         OPC_MOV:  begin cs[CS_ALU_OP +: ALU_BITS] = 3'd6; cs[CS_REG_WR] = 1'b1; end
         OPC_SETC: cs[CS_SET_C] = 1'b1;
         OPC_LDD:  begin
            cs[CS_ALU_SRC] = 1'b1; cs[CS_MEM_RD] = 1'b1; cs[CS_MEM_TO_REG] = 1'b1;
            cs[CS_REG_WR] = 1'b1; cs[CS_IMM_SEL] = 1'b1;
         end
         OPC_STD:  begin
            cs[CS_ALU_SRC] = 1'b1; cs[CS_MEM_WR] = 1'b1; cs[CS_IMM_SEL] = 1'b1;
         end
         OPC_JMP:  cs[CS_JUMP] = 1'b1;
         OPC_CALL: begin cs[CS_JUMP] = 1'b1; cs[CS_PUSH_PC] = 1'b1; end
         OPC_LDM:  begin
            cs[CS_ALU_SRC] = 1'b1; cs[CS_REG_WR] = 1'b1; cs[CS_IMM_SEL] = 1'b1;
         end
         OPC_IADD: begin
            cs[CS_ALU_OP +: ALU_BITS] = 3'd1; cs[CS_ALU_SRC] = 1'b1;
            cs[CS_REG_WR] = 1'b1; cs[CS_IMM_SEL] = 1'b1;
         end
         OPC_RET:  begin cs[CS_POP_PC] = 1'b1; cs[CS_JUMP] = 1'b1; end
         OPC_RTI:  begin
            cs[CS_POP_PC] = 1'b1; cs[CS_JUMP] = 1'b1; cs[CS_RESET_RTI] = 1'b1;
         end
         default:  cs = CS_NOP;
      endcase
      return cs;
   endfunction

endpackage

// File: rtl/decode_stage_p_if.sv
// Fetch-to-decode handshake plus the registered ID/EX bundle.
//   master: fetch/consumer side (drives if_valid, instruction)
//   slave : decode stage (drives if_ready and the id_* bundle)
interface decode_stage_p_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3,
   parameter int unsigned CS_W   = 16
);
   logic              if_valid;
   logic [DATA_W-1:0] instruction;
   logic              if_ready;
   logic              id_valid;
   logic [CS_W-1:0]   id_cs;
   logic [DATA_W-1:0] id_rdata1;
   logic [DATA_W-1:0] id_rdata2;
   logic [DATA_W-1:0] id_imm;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_rd;

   modport master (
      output if_valid, instruction,
      input  if_ready, id_valid, id_cs, id_rdata1, id_rdata2, id_imm,
             id_rs, id_rt, id_rd
   );

   modport slave (
      input  if_valid, instruction,
      output if_ready, id_valid, id_cs, id_rdata1, id_rdata2, id_imm,
             id_rs, id_rt, id_rd
   );
endinterface

// File: rtl/regfile_bypass.sv
// Register file, two combinational read ports, one write port, with
// same-cycle write-to-read bypass.
//   clk, reset          : clock, synchronous active-high reset (clears all registers)
//   we_i/waddr_i/wdata_i: write port, written on the rising edge
//   raddr1_i/raddr2_i   : read addresses
//   rdata1_o_c/rdata2_o_c: read data (combinational)
module regfile_bypass #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_AW-1:0] raddr1_i,
   input  logic [REG_AW-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata1_o_c,
   output logic [DATA_W-1:0] rdata2_o_c
);
   localparam int unsigned NREGS = 1 << REG_AW;

   logic [DATA_W-1:0] regs_q [NREGS];

   // Storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // Reads see a write landing on the same edge.
   always_comb begin
      rdata1_o_c = regs_q[raddr1_i];
      rdata2_o_c = regs_q[raddr2_i];
      if (we_i && (waddr_i == raddr1_i)) rdata1_o_c = wdata_i;
      if (we_i && (waddr_i == raddr2_i)) rdata2_o_c = wdata_i;
   end
endmodule

// File: rtl/decode_stage_p.sv
// Instruction-decode stage: decodes opcodes into a control word, reads
// operands via the bypassed register file, assembles two-word instructions
// and injects an interrupt bundle on an instruction boundary.
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : fetch handshake in, registered ID/EX bundle out
//   stall, flush        : hazard hold / pipeline kill (flush wins)
//   interrupt           : interrupt request, latched into a pending flag
//   wb_en/wb_addr/wb_data: register write-back port
module decode_stage_p
   import decode_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3,
   parameter int unsigned OPC_W  = 4,
   parameter int unsigned CS_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   decode_stage_p_if.slave   bus,
   input  logic              stall,
   input  logic              flush,
   input  logic              interrupt,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data
);
   localparam int unsigned RS_LSB = DATA_W - OPC_W - REG_AW;
   localparam int unsigned RT_LSB = RS_LSB - REG_AW;

   state_e            state_q, state_d;
   logic              int_pend_q, int_pend_d;
   logic [CS_W-1:0]   lat_cs_q, lat_cs_d;
   logic [REG_AW-1:0] lat_rs_q, lat_rs_d;
   logic [REG_AW-1:0] lat_rt_q, lat_rt_d;

   logic              id_valid_q, id_valid_d;
   logic [CS_W-1:0]   id_cs_q, id_cs_d;
   logic [DATA_W-1:0] id_rdata1_q, id_rdata1_d;
   logic [DATA_W-1:0] id_rdata2_q, id_rdata2_d;
   logic [DATA_W-1:0] id_imm_q, id_imm_d;
   logic [REG_AW-1:0] id_rs_q, id_rs_d;
   logic [REG_AW-1:0] id_rt_q, id_rt_d;
   logic [REG_AW-1:0] id_rd_q, id_rd_d;

   logic [OPC_W-1:0]  opc_c;
   logic [REG_AW-1:0] f_rs_c, f_rt_c;
   logic [REG_AW-1:0] raddr1_c, raddr2_c;
   logic [DATA_W-1:0] rdata1_c, rdata2_c;
   logic              if_ready_c, accept_c, take_int_c;

   assign opc_c  = bus.instruction[DATA_W-1 -: OPC_W];
   assign f_rs_c = bus.instruction[RS_LSB +: REG_AW];
   assign f_rt_c = bus.instruction[RT_LSB +: REG_AW];

   // In IMM the operands come from the fields latched with the opcode word.
   assign raddr1_c = (state_q == ST_IMM) ? lat_rs_q : f_rs_c;
   assign raddr2_c = (state_q == ST_IMM) ? lat_rt_q : f_rt_c;

   // A pending interrupt blocks fetch only at an opcode boundary.
   assign if_ready_c = !reset && !stall && !flush && !((state_q == ST_OPC) && int_pend_q);
   assign accept_c   = bus.if_valid && if_ready_c;
   assign take_int_c = (state_q == ST_OPC) && int_pend_q;

   regfile_bypass #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_rf (
      .clk        (clk),
      .reset      (reset),
      .we_i       (wb_en),
      .waddr_i    (wb_addr),
      .wdata_i    (wb_data),
      .raddr1_i   (raddr1_c),
      .raddr2_i   (raddr2_c),
      .rdata1_o_c (rdata1_c),
      .rdata2_o_c (rdata2_c)
   );

   // State and ID/EX register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_OPC;
         int_pend_q  <= 1'b0;
         lat_cs_q    <= '0;
         lat_rs_q    <= '0;
         lat_rt_q    <= '0;
         id_valid_q  <= 1'b0;
         id_cs_q     <= '0;
         id_rdata1_q <= '0;
         id_rdata2_q <= '0;
         id_imm_q    <= '0;
         id_rs_q     <= '0;
         id_rt_q     <= '0;
         id_rd_q     <= '0;
      end else begin
         state_q     <= state_d;
         int_pend_q  <= int_pend_d;
         lat_cs_q    <= lat_cs_d;
         lat_rs_q    <= lat_rs_d;
         lat_rt_q    <= lat_rt_d;
         id_valid_q  <= id_valid_d;
         id_cs_q     <= id_cs_d;
         id_rdata1_q <= id_rdata1_d;
         id_rdata2_q <= id_rdata2_d;
         id_imm_q    <= id_imm_d;
         id_rs_q     <= id_rs_d;
         id_rt_q     <= id_rt_d;
         id_rd_q     <= id_rd_d;
      end
   end

   // Next state, latches and bundle.
   always_comb begin
      state_d     = state_q;
      int_pend_d  = int_pend_q | interrupt;
      lat_cs_d    = lat_cs_q;
      lat_rs_d    = lat_rs_q;
      lat_rt_d    = lat_rt_q;
      id_valid_d  = id_valid_q;
      id_cs_d     = id_cs_q;
      id_rdata1_d = id_rdata1_q;
      id_rdata2_d = id_rdata2_q;
      id_imm_d    = id_imm_q;
      id_rs_d     = id_rs_q;
      id_rt_d     = id_rt_q;
      id_rd_d     = id_rd_q;

      // Bubble unless a stall holds the bundle or a branch below fills it.
      if (flush || !stall) begin
         id_valid_d  = 1'b0;
         id_cs_d     = CS_W'(CS_NOP);
         id_rdata1_d = '0;
         id_rdata2_d = '0;
         id_imm_d    = '0;
         id_rs_d     = '0;
         id_rt_d     = '0;
         id_rd_d     = '0;
      end

      if (flush) begin
         state_d  = ST_OPC;
         lat_cs_d = '0;
         lat_rs_d = '0;
         lat_rt_d = '0;
      end else if (!stall) begin
         if (take_int_c) begin
            id_valid_d = 1'b1;
            id_cs_d    = CS_W'(CS_INT);
            int_pend_d = interrupt;
         end else if (accept_c) begin
            if (state_q == ST_OPC) begin
               if (needs_imm(OPC_BITS'(opc_c))) begin
                  state_d  = ST_IMM;
                  lat_cs_d = CS_W'(decode(OPC_BITS'(opc_c)));
                  lat_rs_d = f_rs_c;
                  lat_rt_d = f_rt_c;
               end else begin
                  id_valid_d  = 1'b1;
                  id_cs_d     = CS_W'(decode(OPC_BITS'(opc_c)));
                  id_rdata1_d = rdata1_c;
                  id_rdata2_d = rdata2_c;
                  id_rs_d     = f_rs_c;
                  id_rt_d     = f_rt_c;
                  id_rd_d     = f_rs_c;
               end
            end else begin
               state_d     = ST_OPC;
               id_valid_d  = 1'b1;
               id_cs_d     = lat_cs_q;
               id_rdata1_d = rdata1_c;
               id_rdata2_d = rdata2_c;
               id_imm_d    = bus.instruction;
               id_rs_d     = lat_rs_q;
               id_rt_d     = lat_rt_q;
               id_rd_d     = lat_rs_q;
            end
         end
      end
   end

   assign bus.if_ready  = if_ready_c;
   assign bus.id_valid  = id_valid_q;
   assign bus.id_cs     = id_cs_q;
   assign bus.id_rdata1 = id_rdata1_q;
   assign bus.id_rdata2 = id_rdata2_q;
   assign bus.id_imm    = id_imm_q;
   assign bus.id_rs     = id_rs_q;
   assign bus.id_rt     = id_rt_q;
   assign bus.id_rd     = id_rd_q;
endmodule
